// File: rtl/mem_dump_tx.sv
// mem_dump_tx: snapshots the watched data-memory window and sends it
// as an 8N1 UART frame of header, data bytes and checksum.
module mem_dump_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          NUM_BYTES    = 20,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] mem_flat,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NUM_BYTES + 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [BW-1:0]          byte_idx;
  logic [8*NUM_BYTES-1:0] snap;
  logic [7:0]             csum;
  logic [7:0]             cur;
  logic                   last_tick;
  logic                   last_byte;
  logic                   data_byte;

  assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == BW'(NUM_BYTES + 1));
  assign data_byte = (byte_idx != '0) && !last_byte;

  // byte currently on the wire: header, a snapshot byte or the checksum
  always_comb begin
    cur = HEADER;
    if (last_byte) begin
      cur = csum;
    end else begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (byte_idx == BW'(k + 1)) cur = snap[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      csum     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            snap     <= mem_flat;
            csum     <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (last_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= cur[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (last_tick) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (last_tick) begin
            cnt <= '0;
            // checksum is complete before its own start bit
            if (data_byte) csum <= csum + cur;
            if (!last_byte) begin
              byte_idx <= byte_idx + BW'(1);
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: directed frame checks for mem_dump_tx using a
// mid-bit sampling UART receiver and hand-computed frame contents.
module tb_mem_dump_tx;

  localparam int CPB = 4;
  localparam int NB  = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [8*NB-1:0] mem_flat = '0;
  logic            tx;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [7:0] fr [0:NB+1];
  logic [7:0] expd [0:NB-1];
  logic [9:0] first_bits;
  int         frame_err;

  int busy_cnt = 0;
  int done_cnt = 0;
  int idle_run = 0;
  int last_gap = -1;
  int idle_txlow = 0;
  logic prev_busy = 1'b0;

  mem_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES(NB),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_flat(mem_flat),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) last_gap = idle_run;
      busy_cnt++;
      idle_run = 0;
    end else begin
      idle_run++;
      if (!tx) idle_txlow++;
    end
    if (done) done_cnt++;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int k = 0; k < NB; k++) mem_flat[8*k +: 8] = expd[k];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic [9:0] bits,
                         output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    b = '0;
    bits = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      chk("rx_timeout", {31'd0, tx}, 32'd0);
      ok = 1'b0;
      return;
    end
    repeat (CPB/2) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(negedge clk);
      bits[i] = tx;
    end
    b = bits[8:1];
  endtask

  task automatic rx_frame();
    logic [7:0] b;
    logic [9:0] bits;
    bit ok;
    frame_err = 0;
    for (int i = 0; i < NB + 2; i++) begin
      rx_byte(b, bits, ok);
      if (!ok) begin
        frame_err++;
        return;
      end
      if (i == 0) first_bits = bits;
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
      fr[i] = b;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_cs);
    int bad;
    bad = 0;
    for (int k = 0; k < NB; k++) if (fr[k+1] !== expd[k]) bad++;
    chk({tag, "_framing"}, frame_err, 0);
    chk({tag, "_header"}, {24'd0, fr[0]}, 32'hA5);
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_csum"}, {24'd0, fr[NB+1]}, {24'd0, exp_cs});
  endtask

  initial begin
    int bc0, dc0, tl0;

    // reset state
    repeat (3) tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // zero window
    for (int k = 0; k < NB; k++) expd[k] = 8'h00;
    load_mem();
    bc0 = busy_cnt;
    dc0 = done_cnt;
    pulse_start();
    rx_frame();
    repeat (5) tick();
    check_frame("zero", 8'h00);
    chk("zero_busy_cycles", busy_cnt - bc0, 880);
    chk("zero_done_pulses", done_cnt - dc0, 1);
    chk("bit_order", {22'd0, first_bits}, 32'h34A);

    // incrementing window
    for (int k = 0; k < NB; k++) expd[k] = 8'(k + 1);
    load_mem();
    pulse_start();
    rx_frame();
    repeat (3) tick();
    check_frame("incr", 8'hD2);

    // all ones
    for (int k = 0; k < NB; k++) expd[k] = 8'hFF;
    load_mem();
    pulse_start();
    rx_frame();
    repeat (3) tick();
    check_frame("ff", 8'hEC);

    // snapshot holds and a start while busy is ignored
    for (int k = 0; k < NB; k++) expd[k] = 8'h11;
    load_mem();
    dc0 = done_cnt;
    pulse_start();
    fork
      rx_frame();
      begin
        repeat (99) tick();
        mem_flat = {NB{8'h22}};
        pulse_start();
      end
    join
    repeat (20) tick();
    check_frame("snap", 8'h54);
    chk("snap_done_pulses", done_cnt - dc0, 1);
    chk("snap_idle_after", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-frame, during the start bit of byte 5
    for (int k = 0; k < NB; k++) expd[k] = 8'(k + 1);
    load_mem();
    pulse_start();
    repeat (201) tick();
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, tx}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    rx_frame();
    repeat (3) tick();
    check_frame("after_rst", 8'hD2);

    // continuous start: two back-to-back frames
    for (int k = 0; k < NB; k++) expd[k] = 8'hFF;
    load_mem();
    dc0 = done_cnt;
    tl0 = idle_txlow;
    start = 1'b1;
    fork
      begin
        rx_frame();
        check_frame("cont1", 8'hEC);
        rx_frame();
      end
      begin
        repeat (900) tick();
        start = 1'b0;
      end
    join
    repeat (20) tick();
    check_frame("cont2", 8'hEC);
    chk("cont_done_pulses", done_cnt - dc0, 2);
    chk("cont_gap", last_gap, 1);
    chk("cont_gap_tx_high", idle_txlow - tl0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Serial transmitter that reports the CPU's watched data-memory window (bytes mem8..mem27) off-chip as a framed UART stream. It sits beside `top` and takes the same byte-wide memory taps the simulation bench prints. On each trigger it snapshots the window and sends a header, the data bytes and a checksum over a single 8N1 line, so a host or bench receiver can check CPU state without probing internal memory.

## Interface
- CLKS_PER_BIT, 16, clk cycles per UART bit (≥2)
- NUM_BYTES, 20, watched bytes per frame (mem8 first)
- HEADER, 8'hA5, first byte of every frame
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a dump frame; sampled each rising edge
- mem_flat  in  8*NUM_BYTES  watched bytes; bits [8k+7:8k] = mem(8+k)
- tx  out  1  UART line, idle high
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at end of frame

## Operation
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0.
- FSM states:
  - IDLE: tx=1. On start=1, latch mem_flat into the snapshot register, clear the checksum, set byte_idx=0 and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < NUM_BYTES+1: increment byte_idx and go to START;
    - else: go to IDLE and pulse done.
- Byte sequence by byte_idx:
  - 0: HEADER
  - 1..NUM_BYTES: snapshot byte (byte_idx−1)
  - NUM_BYTES+1: checksum
- Checksum: 8-bit sum of the NUM_BYTES snapshot bytes, modulo 256; carries discarded. The header is not included. It is accumulated while the data bytes are sent (or precomputed) and must be valid before its START phase.
- The frame content is fixed at the snapshot. Changes on mem_flat during a frame do not affect it.
- start while busy=1 is ignored. It is not queued.
- start held high continuously: back-to-back frames, each new snapshot taken in the IDLE cycle between frames.
- Reset during any state: outputs return to reset values immediately. The partial frame is abandoned and the next frame starts again from the header.

## Timing
- Snapshot edge: the edge where IDLE samples start=1. busy and tx=0 (start bit) appear on the following cycle.
- Bit period: exactly CLKS_PER_BIT cycles. Bit counter runs 0..CLKS_PER_BIT−1 and wraps.
- Frame length: (NUM_BYTES+2)·10·CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle inclusive.
  - 3520 cycles at default parameters.
- done: high for exactly the one cycle after the last stop-bit cycle. busy falls in that same cycle.
- Minimum gap between frames: one IDLE cycle with tx=1.
- No combinational path from any input to tx, busy or done; all outputs are registered.

## Test plan
- All bench runs use CLKS_PER_BIT=4, NUM_BYTES=20.
- Zero window: mem_flat=0, pulse start → bytes A5, 00×20, 00. busy high for 880 cycles, then done pulses exactly once.
- Bit order: first byte, sampled mid-bit → line 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB first, stop).
- Checksum: mem8..mem27 = 0x01..0x14 → data bytes 01..14 in order, checksum D2. With all bytes = FF → checksum EC.
- Snapshot/ignore: start frame with all bytes = 0x11, then change mem_flat to 0x22 and pulse start at cycle 100 → frame carries 0x11×20 and checksum 0x54, and only one done pulse occurs.
- Reset mid-frame: assert rst during byte 5 → tx=1, busy=0 and done=0 asynchronously. After release, a new start sends a complete frame beginning with A5.
- Continuous start: hold start high for 2 frames → two full frames separated by exactly one idle cycle with tx=1, and two done pulses.
